// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM encoding and the MEM/WB payload type for the microRISC memory stage.
package mem_stage_pkg;
  localparam int DW          = 16;
  localparam int AW          = 16;
  localparam int RAW         = 3;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic           mem_to_reg;
    logic           reg_write;
    logic [RAW-1:0] rd;
    logic [DW-1:0]  mem_read_data;
    logic [DW-1:0]  alu_result;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: load-enabled payload plus a valid bit that a bubble clears.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_en,
  input  logic    bubble,
  input  mem_wb_t d,
  output logic    valid,
  output mem_wb_t q
);

  logic    valid_q, valid_d;
  mem_wb_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_en) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (bubble) begin
      // payload holds so downstream sees stable fields behind a bubble
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ready handshake, stalls upstream while
// waiting, aborts after TIMEOUT wait cycles, and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic           ex_mem_read,
  input  logic           ex_mem_write,
  input  logic           ex_mem_to_reg,
  input  logic           ex_reg_write,
  input  logic [RAW-1:0] ex_rd,
  input  logic [DW-1:0]  ex_alu_result,
  input  logic [DW-1:0]  ex_store_data,
  output logic           mem_stall,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [AW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ready,
  output logic           bus_error,
  output logic           wb_valid,
  output logic           wb_mem_to_reg,
  output logic           wb_reg_write,
  output logic [RAW-1:0] wb_rd,
  output logic [DW-1:0]  wb_mem_read_data,
  output logic [DW-1:0]  wb_alu_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_read_q, is_read_d;
  logic           is_we_q, is_we_d;
  logic           mem_to_reg_q, mem_to_reg_d;
  logic           reg_write_q, reg_write_d;
  logic [RAW-1:0] rd_q, rd_d;
  logic [DW-1:0]  alu_q, alu_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  logic    wb_load, wb_bubble, timeout;
  mem_wb_t wb_in, wb_out;

  assign timeout = (state_q == ACCESS) && !dmem_ready && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_read_d    = is_read_q;
    is_we_d      = is_we_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    wb_load      = 1'b0;
    wb_bubble    = 1'b0;
    wb_in        = '0;
    mem_stall    = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    bus_error    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid && (ex_mem_read || ex_mem_write)) begin
          state_d      = ACCESS;
          cnt_d        = '0;
          is_read_d    = ex_mem_read;
          // a load with a stray write bit is treated as a pure load
          is_we_d      = ex_mem_write && !ex_mem_read;
          mem_to_reg_d = ex_mem_to_reg;
          reg_write_d  = ex_reg_write;
          rd_d         = ex_rd;
          alu_d        = ex_alu_result;
          wdata_d      = ex_store_data;
          wb_bubble    = 1'b1;
        end else if (ex_valid) begin
          wb_load          = 1'b1;
          wb_in.mem_to_reg = ex_mem_to_reg;
          wb_in.reg_write  = ex_reg_write;
          wb_in.rd         = ex_rd;
          wb_in.alu_result = ex_alu_result;
        end else begin
          wb_bubble = 1'b1;
        end
      end

      ACCESS: begin
        dmem_req         = 1'b1;
        dmem_we          = is_we_q;
        dmem_addr        = alu_q[AW-1:0];
        dmem_wdata       = wdata_q;
        mem_stall        = !dmem_ready && !timeout;
        wb_in.mem_to_reg = mem_to_reg_q;
        wb_in.reg_write  = reg_write_q;
        wb_in.rd         = rd_q;
        wb_in.alu_result = alu_q;
        if (dmem_ready) begin
          wb_load             = 1'b1;
          wb_in.mem_read_data = is_read_q ? dmem_rdata : '0;
          state_d             = IDLE;
        end else if (timeout) begin
          bus_error       = 1'b1;
          wb_load         = 1'b1;
          wb_in.reg_write = 1'b0;
          state_d         = IDLE;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_read_q    <= 1'b0;
      is_we_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_read_q    <= is_read_d;
      is_we_q      <= is_we_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .load_en (wb_load),
    .bubble  (wb_bubble),
    .d       (wb_in),
    .valid   (wb_valid),
    .q       (wb_out)
  );

  assign wb_mem_to_reg    = wb_out.mem_to_reg;
  assign wb_reg_write     = wb_out.reg_write;
  assign wb_rd            = wb_out.rd;
  assign wb_mem_read_data = wb_out.mem_read_data;
  assign wb_alu_result    = wb_out.alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores, wait states, timeout, reset, ordering.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [RAW-1:0] ex_rd;
  logic [DW-1:0]  ex_alu_result, ex_store_data;
  logic           mem_stall, dmem_req, dmem_we;
  logic [AW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata, dmem_rdata;
  logic           dmem_ready, bus_error;
  logic           wb_valid, wb_mem_to_reg, wb_reg_write;
  logic [RAW-1:0] wb_rd;
  logic [DW-1:0]  wb_mem_read_data, wb_alu_result;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .bus_error(bus_error),
    .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_mem_read_data(wb_mem_read_data), .wb_alu_result(wb_alu_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rd_op, input logic wr_op, input logic m2r,
                          input logic rw, input logic [RAW-1:0] rd, input logic [DW-1:0] alu,
                          input logic [DW-1:0] sd);
    ex_valid      = v;
    ex_mem_read   = rd_op;
    ex_mem_write  = wr_op;
    ex_mem_to_reg = m2r;
    ex_reg_write  = rw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
  endtask

  initial begin
    rst = 1'b1;
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #3;
    chk("rst_req",   {31'b0, dmem_req},  32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_wbv",   {31'b0, wb_valid},  32'd0);
    chk("rst_alu",   {16'b0, wb_alu_result}, 32'd0);
    chk("rst_berr",  {31'b0, bus_error}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // 1: ALU op passes in one cycle, never stalls
    drive_ex(1, 0, 0, 0, 1, 3'd3, 16'h1234, 16'h0);
    #1 chk("t1_stall_pre", {31'b0, mem_stall}, 32'd0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("t1_wbv",   {31'b0, wb_valid},     32'd1);
    chk("t1_alu",   {16'b0, wb_alu_result}, 32'h1234);
    chk("t1_rd",    {29'b0, wb_rd},        32'd3);
    chk("t1_rw",    {31'b0, wb_reg_write}, 32'd1);
    chk("t1_stall", {31'b0, mem_stall},    32'd0);
    tick();
    chk("t1_bubble", {31'b0, wb_valid}, 32'd0);

    // 2: zero-wait load
    dmem_ready = 1'b1;
    dmem_rdata = 16'hABCD;
    drive_ex(1, 1, 0, 1, 1, 3'd5, 16'h0040, 16'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("t2_req",   {31'b0, dmem_req},  32'd1);
    chk("t2_addr",  {16'b0, dmem_addr}, 32'h0040);
    chk("t2_we",    {31'b0, dmem_we},   32'd0);
    chk("t2_stall", {31'b0, mem_stall}, 32'd0);
    chk("t2_wbv0",  {31'b0, wb_valid},  32'd0);
    tick();
    chk("t2_req_off", {31'b0, dmem_req},        32'd0);
    chk("t2_wbv",     {31'b0, wb_valid},        32'd1);
    chk("t2_data",    {16'b0, wb_mem_read_data}, 32'hABCD);
    chk("t2_m2r",     {31'b0, wb_mem_to_reg},   32'd1);
    chk("t2_rd",      {29'b0, wb_rd},           32'd5);
    dmem_ready = 1'b0;

    // 3: store with three wait cycles
    drive_ex(1, 0, 1, 0, 0, 3'd0, 16'h0010, 16'h5A5A);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1'b1;
      #1;
      chk("t3_req",   {31'b0, dmem_req},   32'd1);
      chk("t3_we",    {31'b0, dmem_we},    32'd1);
      chk("t3_addr",  {16'b0, dmem_addr},  32'h0010);
      chk("t3_wdata", {16'b0, dmem_wdata}, 32'h5A5A);
      chk("t3_stall", {31'b0, mem_stall},  (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_ready = 1'b0;
    chk("t3_wbv",  {31'b0, wb_valid},        32'd1);
    chk("t3_rw",   {31'b0, wb_reg_write},    32'd0);
    chk("t3_data", {16'b0, wb_mem_read_data}, 32'h0000);
    chk("t3_req_off", {31'b0, dmem_req},     32'd0);

    // 4: load with no ready -> abort on 16th ACCESS cycle
    drive_ex(1, 1, 0, 1, 1, 3'd2, 16'h0080, 16'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t4_req",   {31'b0, dmem_req},  32'd1);
      chk("t4_berr",  {31'b0, bus_error}, (i == 15) ? 32'd1 : 32'd0);
      chk("t4_stall", {31'b0, mem_stall}, (i == 15) ? 32'd0 : 32'd1);
      tick();
    end
    chk("t4_wbv",     {31'b0, wb_valid},     32'd1);
    chk("t4_rw",      {31'b0, wb_reg_write}, 32'd0);
    chk("t4_rd",      {29'b0, wb_rd},        32'd2);
    chk("t4_berr_off", {31'b0, bus_error},   32'd0);
    chk("t4_idle",    {31'b0, dmem_req},     32'd0);
    drive_ex(1, 0, 0, 0, 1, 3'd1, 16'h0777, 16'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("t4_alu_v",  {31'b0, wb_valid},      32'd1);
    chk("t4_alu",    {16'b0, wb_alu_result}, 32'h0777);
    chk("t4_alu_rw", {31'b0, wb_reg_write},  32'd1);

    // 5: reset in the middle of an access
    drive_ex(1, 1, 0, 1, 1, 3'd7, 16'h0200, 16'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    tick();
    chk("t5_req_pre", {31'b0, dmem_req},      32'd1);
    chk("t5_alu_pre", {16'b0, wb_alu_result}, 32'h0777);
    rst = 1'b1;
    #1;
    chk("t5_req",   {31'b0, dmem_req},      32'd0);
    chk("t5_wbv",   {31'b0, wb_valid},      32'd0);
    chk("t5_alu",   {16'b0, wb_alu_result}, 32'h0000);
    chk("t5_rd",    {29'b0, wb_rd},         32'd0);
    chk("t5_rw",    {31'b0, wb_reg_write},  32'd0);
    #2 rst = 1'b0;
    drive_ex(1, 0, 0, 0, 1, 3'd6, 16'h4321, 16'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("t5_post_v",   {31'b0, wb_valid},      32'd1);
    chk("t5_post_alu", {16'b0, wb_alu_result}, 32'h4321);

    // 6: load, then dependent ALU op held behind a 2-cycle wait
    dmem_rdata = 16'hBEEF;
    drive_ex(1, 1, 0, 1, 1, 3'd4, 16'h0100, 16'h0);
    tick();
    drive_ex(1, 0, 0, 0, 1, 3'd6, 16'h0055, 16'h0);
    chk("t6_stall1", {31'b0, mem_stall}, 32'd1);
    chk("t6_wbv1",   {31'b0, wb_valid},  32'd0);
    tick();
    chk("t6_stall2", {31'b0, mem_stall}, 32'd1);
    tick();
    dmem_ready = 1'b1;
    #1 chk("t6_stall3", {31'b0, mem_stall}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    chk("t6_ld_v",    {31'b0, wb_valid},         32'd1);
    chk("t6_ld_rd",   {29'b0, wb_rd},            32'd4);
    chk("t6_ld_data", {16'b0, wb_mem_read_data}, 32'hBEEF);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("t6_alu_v",   {31'b0, wb_valid},      32'd1);
    chk("t6_alu_rd",  {29'b0, wb_rd},         32'd6);
    chk("t6_alu",     {16'b0, wb_alu_result}, 32'h0055);
    chk("t6_alu_m2r", {31'b0, wb_mem_to_reg}, 32'd0);
    tick();
    chk("t6_bubble", {31'b0, wb_valid}, 32'd0);

    // read and write both set: read wins
    dmem_ready = 1'b1;
    dmem_rdata = 16'h1111;
    drive_ex(1, 1, 1, 1, 1, 3'd2, 16'h0300, 16'hFFFF);
    tick();
    drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
    chk("rw_req",  {31'b0, dmem_req}, 32'd1);
    chk("rw_we",   {31'b0, dmem_we},  32'd0);
    tick();
    dmem_ready = 1'b0;
    chk("rw_data", {16'b0, wb_mem_read_data}, 32'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
